request_returner: RTL

- Sits between the back-end burst handler and the front-end request queues.
- Receives completed requests one per cycle on the burst handler's returner interface. There is no backpressure toward the burst handler.
- Read completions arrive out of order. The block stores them in a reorder buffer indexed by read index and releases them to the front end strictly in index order.
- Write completions are queued in a small FIFO and returned as acknowledgements.

---
 rtl/request_returner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/request_returner.sv
// rtl/request_returner.sv - reorders read completions into index order and queues write acks
module request_returner #(
  parameter int DATA_WIDTH        = 32,
  parameter int READ_ENTRIES_LOG  = 4,
  parameter int WRITE_ENTRIES_LOG = 4,
  parameter int WR_FIFO_DEPTH     = 4,
  localparam int IDX_WIDTH = (READ_ENTRIES_LOG > WRITE_ENTRIES_LOG) ? READ_ENTRIES_LOG
                                                                    : WRITE_ENTRIES_LOG
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_type,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [IDX_WIDTH-1:0]          in_index,
  output logic                          rd_out_valid,
  output logic [DATA_WIDTH-1:0]         rd_out_data,
  output logic [READ_ENTRIES_LOG-1:0]   rd_out_index,
  input  logic                          rd_out_ready,
  output logic                          wr_ack_valid,
  output logic [WRITE_ENTRIES_LOG-1:0]  wr_ack_index,
  input  logic                          wr_ack_ready,
  output logic [READ_ENTRIES_LOG:0]     rd_occupancy,
  output logic                          dup_err,
  output logic                          wr_ovf_err
);

  localparam int RL    = READ_ENTRIES_LOG;
  localparam int WL    = WRITE_ENTRIES_LOG;
  localparam int RD_N  = 1 << RL;
  localparam int FP    = $clog2(WR_FIFO_DEPTH);

  // Reorder buffer storage and per-slot filled flags
  logic [DATA_WIDTH-1:0] slot_q [RD_N];
  logic [RD_N-1:0]       vld_q, vld_d;
  logic [RL-1:0]         head_q, head_d;

  // Registered read output stage
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [RL-1:0]         out_index_q, out_index_d;

  logic [RL:0]           occ_q, occ_d;
  logic                  dup_q, dup_d, ovf_q, ovf_d;

  // Write-ack FIFO with one extra pointer bit to tell full from empty
  logic [WL-1:0]         fifo_q [WR_FIFO_DEPTH];
  logic [FP:0]           wptr_q, wptr_d, rptr_q, rptr_d;

  logic                  rd_cap, cap_hit, load, occ_inc;
  logic [RL-1:0]         cap_idx;
  logic                  wr_push, wr_pop, push_ok, fifo_full, fifo_empty;

  // Next-state for capture, in-order release, occupancy, FIFO pointers and sticky errors
  always_comb begin
    rd_cap      = in_valid && !in_type;
    cap_idx     = in_index[RL-1:0];
    cap_hit     = vld_q[cap_idx];
    load        = vld_q[head_q] && (!out_valid_q || rd_out_ready);

    vld_d       = vld_q;
    head_d      = head_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;

    if (load) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
      out_valid_d   = 1'b1;
      out_data_d    = slot_q[head_q];
      out_index_d   = head_q;
    end else if (rd_out_ready) begin
      out_valid_d   = 1'b0;
    end
    if (rd_cap) begin
      vld_d[cap_idx] = 1'b1;
    end

    // A capture into the head slot being released this cycle refills a slot that is
    // simultaneously emptied, so occupancy keeps tracking the number of set vld bits.
    occ_inc = rd_cap && (!cap_hit || (load && (cap_idx == head_q)));
    occ_d   = occ_q + {{RL{1'b0}}, occ_inc} - {{RL{1'b0}}, load};
    dup_d   = dup_q | (rd_cap && cap_hit);

    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[FP] != rptr_q[FP]) && (wptr_q[FP-1:0] == rptr_q[FP-1:0]);
    wr_push    = in_valid && in_type;
    wr_pop     = !fifo_empty && wr_ack_ready;
    push_ok    = wr_push && (!fifo_full || wr_pop);
    ovf_d      = ovf_q | (wr_push && fifo_full && !wr_pop);
    wptr_d     = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = wr_pop ? rptr_q + 1'b1 : rptr_q;
  end

  // Data arrays are not reset; their contents are qualified by vld_q and the FIFO pointers
  always_ff @(posedge clk) begin
    if (rd_cap) begin
      slot_q[cap_idx] <= in_data;
    end
    if (push_ok) begin
      fifo_q[wptr_q[FP-1:0]] <= in_index[WL-1:0];
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      occ_q       <= '0;
      dup_q       <= 1'b0;
      ovf_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      vld_q       <= vld_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      occ_q       <= occ_d;
      dup_q       <= dup_d;
      ovf_q       <= ovf_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  assign rd_out_valid = out_valid_q;
  assign rd_out_data  = out_data_q;
  assign rd_out_index = out_index_q;
  assign rd_occupancy = occ_q;
  assign dup_err      = dup_q;
  assign wr_ovf_err   = ovf_q;
  assign wr_ack_valid = !fifo_empty;
  assign wr_ack_index = fifo_empty ? '0 : fifo_q[rptr_q[FP-1:0]];

endmodule
